// File: rtl/upg_uart_loader.sv
// UART 8N1 boot loader for the program ROM programming port.
// Packs bytes little-endian into words and writes them at incrementing addresses.
module upg_uart_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int MAX_WORDS    = 16384,
  parameter int IDLE_TIMEOUT = 100000
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_n_i,
  input  logic        rx_i,
  output logic        upg_wen_o,
  output logic [13:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        frame_err_o,
  output logic [14:0] word_cnt_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMAX = TW'(IDLE_TIMEOUT);
  localparam logic [14:0]   WMAX = 15'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT
  } st_e;

  st_e           st_q, st_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   word_q, word_d;
  logic          got_q, got_d;
  logic          wen_q, wen_d;
  logic [13:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic [14:0]   wcnt_q, wcnt_d;

  logic        rx_s;
  logic        byte_vld;
  logic        ferr_set;
  logic        byte_in;
  logic        tmo;
  logic        wr_req;
  logic [31:0] wmerge;
  logic [14:0] wnext;

  assign rx_s = sync_q[1];

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    sh_d     = sh_q;
    byte_vld = 1'b0;
    ferr_set = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s && !done_q) st_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_vld = 1'b1;
            st_d     = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            st_d     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = '0;
        if (rx_s) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    idle_d = '0;
    if (st_q == S_IDLE && rx_s)
      idle_d = (idle_q == TMAX) ? idle_q : idle_q + 1'b1;
    byte_in = byte_vld && !done_q;
    tmo     = got_q && (idle_q == TMAX) && !done_q;
    wmerge  = word_q;
    word_d  = word_q;
    lane_d  = lane_q;
    wr_req  = 1'b0;
    got_d   = got_q | byte_in;
    done_d  = done_q;
    ferr_d  = ferr_q | (ferr_set && !done_q);
    wcnt_d  = wcnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    wnext   = wcnt_q + 15'd1;
    if (byte_in) begin
      wmerge[{lane_q, 3'b000} +: 8] = sh_q;
      word_d = wmerge;
      lane_d = lane_q + 1'b1;
      wr_req = (lane_q == 2'd3);
    end else if (tmo) begin
      // Partial words are flushed first; done follows once lane is 0
      if (lane_q != 2'd0) wr_req = 1'b1;
      else done_d = 1'b1;
    end
    if (wr_req) begin
      dat_d  = wmerge;
      word_d = '0;
      lane_d = '0;
    end
    wen_d = wr_req;
    if (wen_q) begin
      wcnt_d = wnext;
      if (wnext < WMAX) adr_d = adr_q + 14'd1;
      if (wnext == WMAX) done_d = 1'b1;
    end
  end

  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) begin
      sync_q <= 2'b11;
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      idle_q <= '0;
      lane_q <= '0;
      word_q <= '0;
      got_q  <= 1'b0;
      wen_q  <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      idle_q <= idle_d;
      lane_q <= lane_d;
      word_q <= word_d;
      got_q  <= got_d;
      wen_q  <= wen_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign upg_wen_o   = wen_q;
  assign upg_adr_o   = adr_q;
  assign upg_dat_o   = dat_q;
  assign upg_done_o  = done_q;
  assign frame_err_o = ferr_q;
  assign word_cnt_o  = wcnt_q;

endmodule

// File: tb/tb_upg_uart_loader.sv
// Directed and random byte streams for upg_uart_loader,
// checked against a byte-list packing model.
module tb_upg_uart_loader;

  localparam int CPB = 8;
  localparam int MW  = 2;
  localparam int TO  = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        wen;
  logic [13:0] adr;
  logic [31:0] dat;
  logic        done;
  logic        ferr;
  logic [14:0] wcnt;

  always #5 clk = ~clk;

  upg_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .MAX_WORDS(MW),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .upg_clk_i(clk),
    .upg_rst_n_i(rst_n),
    .rx_i(rx),
    .upg_wen_o(wen),
    .upg_adr_o(adr),
    .upg_dat_o(dat),
    .upg_done_o(done),
    .frame_err_o(ferr),
    .word_cnt_o(wcnt)
  );

  int checks = 0;
  int errors = 0;

  logic [13:0] sq_adr[$];
  logic [31:0] sq_dat[$];
  int          cyc = 0;
  int          last_wen_cyc = -1;
  int          done_cyc = -1;
  logic        done_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (wen === 1'b1) begin
        sq_adr.push_back(adr);
        sq_dat.push_back(dat);
        last_wen_cyc = cyc;
      end
      if (done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
      done_prev = done;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, done, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_strobe(input string tag, input int idx,
                            input logic [13:0] ea, input logic [31:0] ed);
    if (idx < sq_adr.size()) begin
      chk({tag, "_adr"}, sq_adr[idx], ea);
      chk({tag, "_dat"}, sq_dat[idx], ed);
    end else begin
      chk({tag, "_present"}, sq_adr.size(), idx + 1);
    end
  endtask

  initial begin
    int base;
    logic [7:0] bq[$];
    int n;
    int nw;
    logic [31:0] w;

    repeat (3) @(negedge clk);
    chk("rst_wen", wen, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat, 0);
    chk("rst_done", done, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_cnt", wcnt, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Two full words reach MAX_WORDS
    base = sq_adr.size();
    bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    foreach (bq[i]) send_byte(bq[i], 1'b1);
    wait_done("s1_done", 400);
    chk("s1_nstrobe", sq_adr.size() - base, 2);
    chk_strobe("s1_w0", base, 14'd0, 32'h12345678);
    chk_strobe("s1_w1", base + 1, 14'd1, 32'hDEADBEEF);
    chk("s1_cnt", wcnt, 2);
    chk("s1_done_lat", done_cyc, last_wen_cyc + 1);

    // Bytes after done are ignored
    base = sq_adr.size();
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (bq[i]) send_byte(bq[i], 1'b1);
    repeat (50) @(negedge clk);
    chk("s2_nstrobe", sq_adr.size() - base, 0);
    chk("s2_adr", adr, 1);
    chk("s2_dat", dat, 32'hDEADBEEF);
    chk("s2_cnt", wcnt, 2);

    // Idle timeout flushes a partial word
    do_reset();
    base = sq_adr.size();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    wait_done("s3_done", 600);
    chk("s3_nstrobe", sq_adr.size() - base, 1);
    chk_strobe("s3_w0", base, 14'd0, 32'h0000BBAA);
    chk("s3_cnt", wcnt, 1);
    chk("s3_done_lat", done_cyc, last_wen_cyc + 1);

    // Framing error drops the byte only
    do_reset();
    base = sq_adr.size();
    send_byte(8'h55, 1'b0);
    chk("s4_ferr", ferr, 1);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (bq[i]) send_byte(bq[i], 1'b1);
    repeat (10) @(negedge clk);
    chk("s4_nstrobe", sq_adr.size() - base, 1);
    chk_strobe("s4_w0", base, 14'd0, 32'h44332211);
    chk("s4_cnt", wcnt, 1);

    // Short low glitch is rejected
    do_reset();
    base = sq_adr.size();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("s5_ferr", ferr, 0);
    chk("s5_nstrobe", sq_adr.size() - base, 0);
    bq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    foreach (bq[i]) send_byte(bq[i], 1'b1);
    repeat (10) @(negedge clk);
    chk_strobe("s5_w0", base, 14'd0, 32'hC4C3C2C1);

    // Reset mid-word discards partial bytes
    do_reset();
    send_byte(8'h99, 1'b1);
    send_byte(8'h88, 1'b1);
    do_reset();
    base = sq_adr.size();
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (bq[i]) send_byte(bq[i], 1'b1);
    repeat (10) @(negedge clk);
    chk("s6_nstrobe", sq_adr.size() - base, 1);
    chk_strobe("s6_w0", base, 14'd0, 32'h04030201);
    chk("s6_cnt", wcnt, 1);

    // Random streams against the packing model
    for (int it = 0; it < 5; it++) begin
      do_reset();
      base = sq_adr.size();
      n = $urandom_range(1, 10);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      foreach (bq[i]) send_byte(bq[i], 1'b1);
      wait_done($sformatf("r%0d_done", it), 800);
      nw = (n + 3) / 4;
      if (nw > MW) nw = MW;
      chk($sformatf("r%0d_nstrobe", it), sq_adr.size() - base, nw);
      chk($sformatf("r%0d_cnt", it), wcnt, nw);
      chk($sformatf("r%0d_ferr", it), ferr, 0);
      for (int j = 0; j < nw; j++) begin
        w = '0;
        for (int k = 0; k < 4; k++)
          if (4 * j + k < n) w = w | (32'(bq[4 * j + k]) << (8 * k));
        chk_strobe($sformatf("r%0d_w%0d", it, j), base + j, 14'(j), w);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
